// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    localparam int PC_W      = 22;
    localparam int IMM_RAW_W = 19;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

endpackage : fetch_pkg

// File: rtl/instr_hold_buffer.sv
// One-entry hold register for the instruction-memory read data.
// While decode is stalled, the memory keeps reading the next address,
// so the word already in decode must be captured here.
module instr_hold_buffer #(
    parameter int INSTR_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   sel_hold,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr
);

    logic [INSTR_WIDTH-1:0] hold_q;

    // Capture the word currently in decode when a stall begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else if (load) begin
            hold_q <= imem_rdata;
        end
    end

    // Present the held word while stalled, otherwise the live memory data.
    always_comb begin
        instr = sel_hold ? hold_q : imem_rdata;
    end

endmodule : instr_hold_buffer

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, synchronous instruction
// memory interface, decode slot, stall/flush/redirect handling.
// Optional build macro FETCH_PERF_EN adds the fetched/bubble counters;
// without it both perf ports are tied to zero and no counter flops exist.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset, memory data not yet meaningful
// RUN   | decode shows live imem_rdata
// STALL | decode shows the hold buffer; memory already returns next word
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_W,
    parameter int                  INSTR_WIDTH = 24,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall_d,
    input  logic                   flush_d,
    input  logic                   branch_taken_e,
    input  logic [PC_WIDTH-1:0]    branch_target_e,
    output logic [INSTR_WIDTH-1:0] instr_d,
    output logic [IMM_RAW_W-1:0]   imm_d,
    output logic [PC_WIDTH-1:0]    pc_d,
    output logic                   valid_d,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_bubbles
);

    fetch_state_t        state, state_nxt;
    logic [PC_WIDTH-1:0] pc_f, pc_f_nxt;
    logic [PC_WIDTH-1:0] pc_d_nxt;
    logic                valid_nxt;
    logic                hold_load;

    // State, PC and decode-slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            pc_f    <= RESET_PC;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_f    <= pc_f_nxt;
            pc_d    <= pc_d_nxt;
            valid_d <= valid_nxt;
        end
    end

    // Priority: redirect, flush, stall, advance. PC wraps silently.
    always_comb begin
        state_nxt = state;
        pc_f_nxt  = pc_f;
        pc_d_nxt  = pc_d;
        valid_nxt = valid_d;
        hold_load = 1'b0;
        if (branch_taken_e) begin
            pc_f_nxt  = branch_target_e;
            valid_nxt = 1'b0;
            state_nxt = RUN;
        end else if (flush_d && !stall_d) begin
            pc_d_nxt  = pc_f;
            pc_f_nxt  = pc_f + PC_WIDTH'(1);
            valid_nxt = 1'b0;
            state_nxt = RUN;
        end else if (stall_d) begin
            if (state == RUN) begin
                hold_load = 1'b1;
                state_nxt = STALL;
            end
            if (flush_d) begin
                valid_nxt = 1'b0;
            end
        end else begin
            pc_d_nxt  = pc_f;
            pc_f_nxt  = pc_f + PC_WIDTH'(1);
            valid_nxt = 1'b1;
            state_nxt = RUN;
        end
    end

    instr_hold_buffer #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .sel_hold   (state == STALL),
        .imem_rdata (imem_rdata),
        .instr      (instr_d)
    );

    assign imem_addr = pc_f;
    assign imm_d     = instr_d[IMM_RAW_W-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    // Count instructions accepted by decode and empty decode cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (valid_d && !stall_d) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (!valid_d) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a PC-level model predicts pc_f, pc_d
// and valid_d each cycle; instruction content follows from the memory
// image (word i = i + 24'h100000), so a valid slot must hold mem(pc_d).
module tb_fetch_stage;

    localparam int               PW      = 22;
    localparam int               IW      = 24;
    localparam logic [PW-1:0]    RST_PC  = 22'h000010;

    typedef struct {
        logic [PW-1:0] pc_f;
        logic [PW-1:0] pc_d;
        logic          valid;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          stall_d, flush_d, branch_taken_e;
    logic [PW-1:0] branch_target_e;
    logic [IW-1:0] instr_d;
    logic [18:0]   imm_d;
    logic [PW-1:0] pc_d;
    logic          valid_d;
    logic [31:0]   perf_fetched, perf_bubbles;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    logic [PW-1:0] m_pc_f, m_pc_d;
    logic          m_valid;
    logic [31:0]   m_fetched, m_bubbles;

    fetch_stage #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .branch_taken_e  (branch_taken_e),
        .branch_target_e (branch_target_e),
        .instr_d         (instr_d),
        .imm_d           (imm_d),
        .pc_d            (pc_d),
        .valid_d         (valid_d),
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return {2'b00, a} + 24'h100000;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc_f    = RST_PC;
        m_pc_d    = '0;
        m_valid   = 1'b0;
        m_fetched = '0;
        m_bubbles = '0;
    endtask

    // Drive one cycle of inputs, advance the model, push the expected outcome.
    task automatic step(input logic br, input logic [PW-1:0] tgt, input logic st, input logic fl);
        exp_t e;
        branch_taken_e  = br;
        branch_target_e = tgt;
        stall_d         = st;
        flush_d         = fl;
        if (!m_valid) m_bubbles++;
        if (m_valid && !st) m_fetched++;
        if (br) begin
            m_pc_f  = tgt;
            m_valid = 1'b0;
        end else if (fl && !st) begin
            m_pc_d  = m_pc_f;
            m_pc_f  = m_pc_f + 22'd1;
            m_valid = 1'b0;
        end else if (st) begin
            if (fl) m_valid = 1'b0;
        end else begin
            m_pc_d  = m_pc_f;
            m_pc_f  = m_pc_f + 22'd1;
            m_valid = 1'b1;
        end
        e.pc_f  = m_pc_f;
        e.pc_d  = m_pc_d;
        e.valid = m_valid;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_step();
        logic          br, st, fl;
        logic [PW-1:0] tgt;
        br  = ($urandom_range(0, 9) == 0);
        st  = ($urandom_range(0, 3) == 0);
        fl  = ($urandom_range(0, 7) == 0);
        tgt = ($urandom_range(0, 1) == 0) ? PW'($urandom)
                                          : 22'h3FFFF8 + PW'($urandom_range(0, 7));
        step(br, tgt, st, fl);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(RST_PC));
        chk({tag, "_pc_d"}, 64'(pc_d), 64'd0);
        chk({tag, "_valid_d"}, 64'(valid_d), 64'd0);
        chk({tag, "_perf_fetched"}, 64'(perf_fetched), 64'd0);
        chk({tag, "_perf_bubbles"}, 64'(perf_bubbles), 64'd0);
    endtask

    // Monitor: compare the DUT outputs after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr", 64'(imem_addr), 64'(e.pc_f));
                chk("pc_d", 64'(pc_d), 64'(e.pc_d));
                chk("valid_d", 64'(valid_d), 64'(e.valid));
                if (e.valid) begin
                    chk("instr_d", 64'(instr_d), 64'(mem_word(e.pc_d)));
                    chk("imm_d", 64'(imm_d), 64'(mem_word(e.pc_d) & 24'h07FFFF));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        stall_d         = 1'b0;
        flush_d         = 1'b0;
        branch_taken_e  = 1'b0;
        branch_target_e = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Boot and free-run; stall three cycles with pc_d = 0x12.
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        // Redirect to 0x200.
        step(1'b1, 22'h000200, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        // Redirect while already stalled: hold contents must be dropped.
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 22'h000200, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        // PC wrap at the top of the address space.
        step(1'b1, 22'h3FFFFE, 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0, 1'b0);

        // Flush alone, flush with stall.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

        repeat (400) rand_step();

        // Asynchronous reset mid-operation.
        step(1'b1, 22'h000300, 1'b1, 1'b0);
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        branch_taken_e = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_values("midreset");
        model_reset();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        repeat (200) rand_step();
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

`ifdef FETCH_PERF_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        chk("perf_bubbles", 64'(perf_bubbles), 64'(m_bubbles));
`else
        chk("perf_fetched_off", 64'(perf_fetched), 64'd0);
        chk("perf_bubbles_off", 64'(perf_bubbles), 64'd0);
`endif
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
